// File: rtl/bingo_engine.sv
// Bingo draw engine: scans the card RAM for each drawn number, marks hits, detects winners.
// Optional feature: define BINGO_REPEAT_REJECT_EN to reject numbers that were already drawn.
module bingo_engine #(
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_PLAYERS        = 2,
    parameter int ENTRIES_PER_PLAYER = 8,
    parameter int ADDR_WIDTH         = 4,
    parameter int TICK_COUNT         = 50
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start_game,
    input  logic                                      next_edge,
    input  logic [DATA_WIDTH-1:0]                     guessed_number,
    input  logic [DATA_WIDTH-1:0]                     ram_read_number,
    output logic [ADDR_WIDTH-1:0]                     ram_addr,
    output logic                                      ram_write_en,
    output logic                                      ram_delete,
    output logic                                      enable_displays,
    output logic [NUM_PLAYERS*ENTRIES_PER_PLAYER-1:0] game_state,
    output logic [DATA_WIDTH-1:0]                     guessed_number_r,
    output logic                                      toggle_1s,
    output logic                                      endgame,
    output logic [NUM_PLAYERS-1:0]                    winner,
    output logic [7:0]                                guess_count,
    output logic                                      dup_guess
);

    localparam int TOTAL = NUM_PLAYERS * ENTRIES_PER_PLAYER;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(TOTAL - 1);
    localparam int TW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_LOAD, S_READ, S_CMP, S_MARK, S_CHECK, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [TOTAL-1:0]        gs_q, gs_d;
    logic [DATA_WIDTH-1:0]   gnr_q, gnr_d;
    logic [NUM_PLAYERS-1:0]  win_q, win_d;
    logic [NUM_PLAYERS-1:0]  full;
    logic [7:0]              gc_q, gc_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic                    tog_q, tog_d;
`ifdef BINGO_REPEAT_REJECT_EN
    logic [2**DATA_WIDTH-1:0] hist_q, hist_d;
    logic                     dup_q, dup_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        gs_d    = gs_q;
        gnr_d   = gnr_q;
        win_d   = win_q;
        gc_d    = gc_q;
        tick_d  = tick_q;
        tog_d   = tog_q;
`ifdef BINGO_REPEAT_REJECT_EN
        hist_d  = hist_q;
        dup_d   = 1'b0;
`endif
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            full[p] = &gs_q[p*ENTRIES_PER_PLAYER +: ENTRIES_PER_PLAYER];
        end
        unique case (state_q)
            S_IDLE: if (start_game) state_d = S_WAIT;
            S_WAIT: begin
                if (tick_q == TICK_MAX) begin
                    tick_d = '0;
                    tog_d  = ~tog_q;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
                if (next_edge) state_d = S_LOAD;
            end
            S_LOAD: begin
                gnr_d   = guessed_number;
                addr_d  = '0;
                state_d = S_READ;
`ifdef BINGO_REPEAT_REJECT_EN
                if (hist_q[guessed_number]) begin
                    dup_d   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    hist_d[guessed_number] = 1'b1;
                    gc_d = (gc_q == 8'hFF) ? gc_q : gc_q + 8'd1;
                end
`else
                gc_d = (gc_q == 8'hFF) ? gc_q : gc_q + 8'd1;
`endif
            end
            S_READ: state_d = S_CMP;
            S_CMP: begin
                if (ram_read_number == gnr_q) begin
                    state_d = S_MARK;
                end else if (addr_q == LAST) begin
                    state_d = S_CHECK;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_MARK: begin
                gs_d[addr_q] = 1'b1;
                if (addr_q == LAST) begin
                    state_d = S_CHECK;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_CHECK: begin
                win_d   = win_q | full;
                state_d = (|full) ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                if (start_game) begin
                    gs_d    = '0;
                    win_d   = '0;
                    gc_d    = '0;
                    state_d = S_WAIT;
`ifdef BINGO_REPEAT_REJECT_EN
                    hist_d  = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            gs_q    <= '0;
            gnr_q   <= '0;
            win_q   <= '0;
            gc_q    <= '0;
            tick_q  <= '0;
            tog_q   <= 1'b0;
`ifdef BINGO_REPEAT_REJECT_EN
            hist_q  <= '0;
            dup_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            gs_q    <= gs_d;
            gnr_q   <= gnr_d;
            win_q   <= win_d;
            gc_q    <= gc_d;
            tick_q  <= tick_d;
            tog_q   <= tog_d;
`ifdef BINGO_REPEAT_REJECT_EN
            hist_q  <= hist_d;
            dup_q   <= dup_d;
`endif
        end
    end

    // Strobes are gated by rst so a reset landing on MARK never writes.
    assign ram_write_en     = (state_q == S_MARK) && !rst;
    assign ram_delete       = (state_q == S_MARK) && !rst;
    assign enable_displays  = (state_q == S_CMP);
    assign endgame          = (state_q == S_DONE);
    assign ram_addr         = addr_q;
    assign game_state       = gs_q;
    assign guessed_number_r = gnr_q;
    assign winner           = win_q;
    assign guess_count      = gc_q;
    assign toggle_1s        = tog_q;
`ifdef BINGO_REPEAT_REJECT_EN
    assign dup_guess        = dup_q;
`else
    assign dup_guess        = 1'b0;
`endif

endmodule

// File: tb/tb_bingo_engine.sv
// Directed bench for bingo_engine with a behavioural card RAM and a write-address scoreboard.
module tb_bingo_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_game = 1'b0;
    logic        next_edge = 1'b0;
    logic [7:0]  guessed_number = '0;
    logic [7:0]  ram_read_number;
    logic [3:0]  ram_addr;
    logic        ram_write_en, ram_delete, enable_displays;
    logic [15:0] game_state;
    logic [7:0]  guessed_number_r;
    logic        toggle_1s, endgame;
    logic [1:0]  winner;
    logic [7:0]  guess_count;
    logic        dup_guess;

    int total = 0;
    int bad = 0;
    int cmp_cnt = 0;
    int dup_cnt = 0;
    int tog_edges = 0;
    logic tog_prev = 1'b0;
    logic [3:0] exp_q[$];
    logic [7:0] ram [16];

    always #5 clk = ~clk;

    bingo_engine #(
        .DATA_WIDTH(8), .NUM_PLAYERS(2), .ENTRIES_PER_PLAYER(8),
        .ADDR_WIDTH(4), .TICK_COUNT(50)
    ) dut (
        .clk(clk), .rst(rst), .start_game(start_game), .next_edge(next_edge),
        .guessed_number(guessed_number), .ram_read_number(ram_read_number),
        .ram_addr(ram_addr), .ram_write_en(ram_write_en), .ram_delete(ram_delete),
        .enable_displays(enable_displays), .game_state(game_state),
        .guessed_number_r(guessed_number_r), .toggle_1s(toggle_1s),
        .endgame(endgame), .winner(winner), .guess_count(guess_count),
        .dup_guess(dup_guess)
    );

    always @(posedge clk) begin
        ram_read_number <= ram[ram_addr];
        if (ram_write_en && ram_delete) ram[ram_addr] <= 8'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_write_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {28'd0, ram_addr}, 32'hFFFF_FFFF);
            end else begin
                chk("write_addr", {28'd0, ram_addr}, {28'd0, exp_q.pop_front()});
            end
        end
        if (enable_displays) cmp_cnt++;
        if (dup_guess) dup_cnt++;
        if (toggle_1s !== tog_prev) tog_edges++;
        tog_prev = toggle_1s;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start_game = 1'b0; next_edge = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic fill_seq();
        for (int k = 0; k < 16; k++) ram[k] = 8'(k + 1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_game = 1'b1;
        @(posedge clk); #1 start_game = 1'b0;
    endtask

    task automatic draw(input logic [7:0] g);
        cmp_cnt = 0;
        @(posedge clk); #1;
        guessed_number = g; next_edge = 1'b1;
        @(posedge clk); #1 next_edge = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("sb_drain", exp_q.size(), 0);
    endtask

    initial begin
        logic seen;
        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_addr", {28'd0, ram_addr}, 0);
        chk("rst_gs", {16'd0, game_state}, 0);
        chk("rst_gc", {24'd0, guess_count}, 0);
        chk("rst_win", {30'd0, winner}, 0);
        chk("rst_tog", {31'd0, toggle_1s}, 0);
        chk("rst_end", {31'd0, endgame}, 0);
        chk("rst_we", {31'd0, ram_write_en}, 0);

        // single hit
        fill_seq();
        pulse_start();
        exp_q.push_back(4'd4);
        draw(8'd5);
        chk("hit5_gs", {16'd0, game_state}, 32'h0010);
        chk("hit5_gc", {24'd0, guess_count}, 1);
        chk("hit5_gnr", {24'd0, guessed_number_r}, 5);
        chk("hit5_cmp", cmp_cnt, 16);

        // no-match draw
        draw(8'd200);
        chk("miss_cmp", cmp_cnt, 16);
        chk("miss_gs", {16'd0, game_state}, 32'h0010);
        chk("miss_gc", {24'd0, guess_count}, 2);

        // duplicates on two cards
        do_reset();
        fill_seq();
        ram[3] = 8'd7; ram[6] = 8'd100; ram[11] = 8'd7;
        pulse_start();
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd11);
        draw(8'd7);
        chk("dup_gs", {16'd0, game_state}, 32'h0808);

        // player 0 wins
        do_reset();
        fill_seq();
        pulse_start();
        for (int g = 1; g <= 8; g++) begin
            exp_q.push_back(4'(g - 1));
            draw(8'(g));
            if (g == 7) chk("p0_end7", {31'd0, endgame}, 0);
        end
        chk("p0_win", {30'd0, winner}, 32'b01);
        chk("p0_end", {31'd0, endgame}, 1);
        chk("p0_gs", {16'd0, game_state}, 32'h00FF);
        draw(8'd9);
        chk("done_ign_gc", {24'd0, guess_count}, 8);
        chk("done_ign_gnr", {24'd0, guessed_number_r}, 8);
        chk("done_ign_cmp", cmp_cnt, 0);
        chk("done_ign_end", {31'd0, endgame}, 1);
        pulse_start();
        @(negedge clk);
        chk("restart_gs", {16'd0, game_state}, 0);
        chk("restart_win", {30'd0, winner}, 0);
        chk("restart_gc", {24'd0, guess_count}, 0);
        chk("restart_end", {31'd0, endgame}, 0);

        // simultaneous winners
        do_reset();
        for (int k = 0; k < 16; k++) ram[k] = 8'((k % 8) + 1);
        pulse_start();
        for (int g = 1; g <= 8; g++) begin
            exp_q.push_back(4'(g - 1));
            exp_q.push_back(4'(g + 7));
            draw(8'(g));
        end
        chk("both_win", {30'd0, winner}, 32'b11);
        chk("both_gs", {16'd0, game_state}, 32'hFFFF);

        // repeated draw
        do_reset();
        fill_seq();
        pulse_start();
        exp_q.push_back(4'd8);
        draw(8'd9);
        dup_cnt = 0;
        draw(8'd9);
`ifdef BINGO_REPEAT_REJECT_EN
        chk("rep_dup", dup_cnt, 1);
        chk("rep_gc", {24'd0, guess_count}, 1);
        chk("rep_cmp", cmp_cnt, 0);
`else
        chk("rep_dup", dup_cnt, 0);
        chk("rep_gc", {24'd0, guess_count}, 2);
        chk("rep_cmp", cmp_cnt, 16);
`endif
        chk("rep_gs", {16'd0, game_state}, 32'h0100);

        // reset right after a MARK, then blink timing
        do_reset();
        fill_seq();
        pulse_start();
        exp_q.push_back(4'd6);
        @(posedge clk); #1;
        guessed_number = 8'd7; next_edge = 1'b1;
        @(posedge clk); #1 next_edge = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (ram_write_en) seen = 1'b1;
        end
        chk("mark_seen", {31'd0, seen}, 1);
        @(posedge clk); #1 rst = 1'b1;
        chk("rst_we_mid", {31'd0, ram_write_en}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_addr", {28'd0, ram_addr}, 0);
        chk("mid_gs", {16'd0, game_state}, 0);
        chk("mid_gnr", {24'd0, guessed_number_r}, 0);
        chk("mid_gc", {24'd0, guess_count}, 0);
        chk("mid_cmp", {31'd0, enable_displays}, 0);
        chk("mid_tog", {31'd0, toggle_1s}, 0);
        exp_q.delete();
        pulse_start();
        tog_edges = 0;
        repeat (60) @(posedge clk);
        #1;
        chk("tog_edges", tog_edges, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
